// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package mips_cpu_muldiv_pkg;

  // Operation codes; 6 and 7 are reserved and ignored by the unit.
  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  // True for the four iterative operations (MULT, MULTU, DIV, DIVU).
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One iteration of the shared multiply/divide datapath.
// Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
// Divide:   acc = {partial remainder, dividend bits / quotient bits}, shifted left.
module mips_cpu_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;

  // Shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    addend    = acc[0] ? operand : '0;
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff      = rem_shift - {1'b0, operand};
    if (!is_div) begin
      // Carry out of the add lands in the top bit after the right shift.
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      // Divisor fits: keep the difference, shift in quotient bit 1.
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      // Divisor does not fit: restore (keep shifted remainder), quotient bit 0.
      acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Handshake: a request is taken when start=1 in a cycle where busy=0;
// busy stays high while the iterative operation runs, and done pulses for
// one cycle once hi/lo carry the result. Requests while busy are dropped.
module mips_cpu_muldiv_unit
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo,
  output muldiv_state_t       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic               neg_lo_q;
  logic               neg_hi_q;
  logic               dz_q;
  logic               done_q;

  logic               accept;
  logic               load;
  logic               op_signed;
  logic               op_div;
  logic               op_dz;
  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Requests are taken whenever no iteration is in flight, including the
  // FIX cycle, so a back-to-back request is never lost.
  assign accept    = start && (state_q != RUN);
  assign load      = accept && is_iter_op(op);
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign dbg_state = state_q;

  // Operand conditioning: magnitudes for signed ops, raw values otherwise.
  always_comb begin
    op_signed = ~op[0];
    op_div    = op[1];
    op_dz     = op_div && (b == '0);
    src_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    src_b     = (op_signed && b[WIDTH-1]) ? -b : b;
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = load ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .is_div   (is_div_q),
    .acc_next (acc_next)
  );

  // Operand capture on accept, one datapath step per cycle while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else if (load) begin
      cnt_q    <= CNT_W'(WIDTH);
      is_div_q <= op_div;
      neg_lo_q <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_q <= op_signed && a[WIDTH-1];
      dz_q     <= op_dz;
      if (op_div) begin
        acc_q  <= {{WIDTH{1'b0}}, src_a};
        // A zero divisor frees the operand register to keep the raw
        // dividend, which is what hi must return in that case.
        opnd_q <= op_dz ? a : src_b;
      end else begin
        acc_q  <= {{WIDTH{1'b0}}, src_b};
        opnd_q <= src_a;
      end
    end else if (state_q == RUN) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Sign correction and special cases for the final result.
  always_comb begin
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    if (dz_q) begin
      res_hi = opnd_q;
      res_lo = '1;
    end else if (is_div_q) begin
      res_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      res_lo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // HI/LO registers: result write in FIX, then MTHI/MTLO in program order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      if (state_q == FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (accept && (op == MTHI)) hi <= a;
      if (accept && (op == MTLO)) lo <= a;
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// Directed bench for mips_cpu_muldiv_unit (WIDTH=32).
module tb_mips_cpu_muldiv_unit;
  import mips_cpu_muldiv_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  muldiv_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[14];

  mips_cpu_muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  // Issue one iterative op, then watch busy/done edge by edge (bounded).
  task automatic run_op(input int idx, input vec_t v);
    int done_edge;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    @(negedge clk);
    start = 1'b0;
    a  = $urandom;
    b  = $urandom;
    op = 3'($urandom_range(0, 7));
    busy_cnt  = busy ? 1 : 0;
    done_edge = -1;
    for (int k = 1; k <= 40 && done_edge < 0; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_edge = k;
    end
    check($sformatf("v%0d done_edge", idx), 64'(done_edge), 64'd33);
    check($sformatf("v%0d busy_cycles", idx), 64'(busy_cnt), 64'd32);
    check($sformatf("v%0d hi", idx), 64'(hi), 64'(v.hi));
    check($sformatf("v%0d lo", idx), 64'(lo), 64'(v.lo));
    @(negedge clk);
    check($sformatf("v%0d done_pulse_end", idx), 64'(done), 64'd0);
    check($sformatf("v%0d hold", idx), {hi, lo}, {v.hi, v.lo});
  endtask

  initial begin
    int done_cnt;
    int first_done;

    vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    vecs[7]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    vecs[9]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[11] = '{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[12] = '{DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[13] = '{MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

    // Reset block.
    reset = 1'b1; start = 1'b1; op = MULT; a = 32'h5; b = 32'h6;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    start = 1'b0;
    reset = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 14; i++) run_op(i, vecs[i]);

    // start while busy is ignored; done pulses once.
    @(negedge clk);
    start = 1'b1; op = MULT; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; first_done = -1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 10) begin start = 1'b1; op = DIV; a = 32'd100; b = 32'd3; end
      if (k == 11) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
    end
    check("busy_start_done_cnt", 64'(done_cnt), 64'd1);
    check("busy_start_done_edge", 64'(first_done), 64'd33);
    check("busy_start_hilo", {hi, lo}, {32'h0, 32'h1E});

    // MTHI then MTLO on consecutive cycles.
    @(negedge clk);
    start = 1'b1; op = MTHI; a = 32'h12345678; b = 32'hDEADBEEF;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_lo", 64'(lo), 64'h1E);
    check("mthi_done", 64'(done), 64'd0);
    check("mthi_busy", 64'(busy), 64'd0);
    op = MTLO; a = 32'h9ABCDEF0;
    @(negedge clk);
    check("mtlo_hilo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});
    check("mtlo_done", 64'(done), 64'd0);

    // Reserved op leaves everything untouched.
    op = 3'd6; a = 32'h0BADF00D;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    check("reserved_hilo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});
    check("reserved_state", 64'(dbg_state), 64'(IDLE));
    check("reserved_busy", 64'(busy), 64'd0);

    // Reset mid-operation aborts with no partial result.
    start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_hilo_after", {hi, lo}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
